// File: rtl/rgb_led_pwm_ctrl_if.sv
// Register write channel for the RGB LED PWM controller: valid/ready handshake
// carrying a 2-bit register address and 8-bit data.
interface rgb_led_pwm_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/rgb_led_pwm_ctrl.sv
// Three-channel 8-bit PWM driver for the board RGB LED with OFF/STATIC/BLINK/FADE
// modes; configuration is double-buffered and only takes effect at frame boundaries.
module rgb_led_pwm_ctrl #(
    parameter int PRESCALE = 48
) (
    input  logic              clock,
    input  logic              reset,
    rgb_led_pwm_ctrl_if.slave wr,
    output logic              led_r,
    output logic              led_g,
    output logic              led_b,
    output logic              frame
);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STATIC = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_FADE   = 2'b11
    } mode_t;

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]   r_pre_cnt;
    logic [7:0]      r_pwm_cnt;
    logic            r_ready;
    logic [2:0][7:0] r_sh_duty;
    mode_t           r_sh_mode;
    logic [5:0]      r_sh_period;
    logic [2:0][7:0] r_act_duty;
    logic [5:0]      r_act_period;
    mode_t           r_mode;
    mode_t           w_mode_next;
    logic [5:0]      r_frame_cnt;
    logic            r_blink_on;
    logic [7:0]      r_level;
    logic            r_dir_down;

    logic            w_tick;
    logic            w_frame_end;
    logic            w_wr_fire;
    logic [5:0]      w_p;
    logic [8:0]      w_level_sum;
    logic [2:0][7:0] w_eff;

    assign wr.wr_ready   = r_ready & ~reset;
    assign w_tick        = (r_pre_cnt == PW'(PRESCALE - 1));
    assign w_frame_end   = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_wr_fire     = wr.wr_valid && wr.wr_ready;
    assign w_p           = (r_act_period == 6'd0) ? 6'd1 : r_act_period;
    assign w_level_sum   = {1'b0, r_level} + {3'b000, w_p};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready   <= 1'b1;
            r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PW'(1);
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sh_duty   <= '0;
            r_sh_mode   <= MODE_OFF;
            r_sh_period <= '0;
        end else if (w_wr_fire) begin
            case (wr.wr_addr)
                2'd0:    r_sh_duty[0] <= wr.wr_data;
                2'd1:    r_sh_duty[1] <= wr.wr_data;
                2'd2:    r_sh_duty[2] <= wr.wr_data;
                default: begin
                    r_sh_mode   <= mode_t'(wr.wr_data[7:6]);
                    r_sh_period <= wr.wr_data[5:0];
                end
            endcase
        end
    end

    // Active config reads the shadow as it stood before this edge, so a write
    // landing on frame_end is deferred to the following frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_act_duty   <= '0;
            r_act_period <= '0;
        end else if (w_frame_end) begin
            r_act_duty   <= r_sh_duty;
            r_act_period <= r_sh_period;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_next;
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (w_frame_end) begin
            w_mode_next = r_sh_mode;
        end
    end

    // Per-frame effect state advances with the period of the frame just ended.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_blink_on  <= 1'b1;
            r_level     <= '0;
            r_dir_down  <= 1'b0;
        end else if (w_frame_end) begin
            if (r_sh_mode != r_mode) begin
                r_frame_cnt <= '0;
                r_blink_on  <= 1'b1;
                r_level     <= '0;
                r_dir_down  <= 1'b0;
            end else if (r_mode == MODE_BLINK) begin
                if (r_frame_cnt >= w_p - 6'd1) begin
                    r_frame_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 6'd1;
                end
            end else if (r_mode == MODE_FADE) begin
                if (!r_dir_down) begin
                    if (w_level_sum >= 9'd255) begin
                        r_level    <= 8'd255;
                        r_dir_down <= 1'b1;
                    end else begin
                        r_level    <= w_level_sum[7:0];
                    end
                end else begin
                    if (r_level <= {2'b00, w_p}) begin
                        r_level    <= 8'd0;
                        r_dir_down <= 1'b0;
                    end else begin
                        r_level    <= r_level - {2'b00, w_p};
                    end
                end
            end
        end
    end

    always_comb begin
        w_eff = '0;
        for (int c = 0; c < 3; c++) begin
            case (r_mode)
                MODE_STATIC: w_eff[c] = r_act_duty[c];
                MODE_BLINK:  w_eff[c] = r_blink_on ? r_act_duty[c] : 8'd0;
                MODE_FADE:   w_eff[c] = 8'((16'(r_act_duty[c]) * 16'(r_level)) >> 8);
                default:     w_eff[c] = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            led_r <= 1'b0;
            led_g <= 1'b0;
            led_b <= 1'b0;
            frame <= 1'b0;
        end else begin
            led_r <= (r_pwm_cnt < w_eff[0]);
            led_g <= (r_pwm_cnt < w_eff[1]);
            led_b <= (r_pwm_cnt < w_eff[2]);
            frame <= w_frame_end;
        end
    end

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Bench for rgb_led_pwm_ctrl: frame-level reference model compared every cycle,
// directed scenarios pinned by per-frame high counts, plus randomized writes.
module tb_rgb_led_pwm_ctrl;
    localparam int PS         = 1;
    localparam int FRAME_CLKS = 256 * PS;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic led_r, led_g, led_b, frame;

    rgb_led_pwm_ctrl_if wrIf ();

    rgb_led_pwm_ctrl #(.PRESCALE(PS)) dut (
        .clock (clock),
        .reset (reset),
        .wr    (wrIf),
        .led_r (led_r),
        .led_g (led_g),
        .led_b (led_b),
        .frame (frame)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference state: time since reset in clocks, shadow/active config, effect state.
    int cyc;
    int shDuty [3];
    int actDuty [3];
    int shMode, actMode, shPeriod, actPeriod;
    int phaseAge, level;
    bit blinkOn, goingUp;
    bit modelLive = 1'b0;
    bit expReadyReg;
    bit expFrame;
    bit expLed [3];

    int cntR[$], cntG[$], cntB[$];
    int accR = 0, accG = 0, accB = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int effectiveDuty(input int ch);
        case (actMode)
            1:       return actDuty[ch];
            2:       return blinkOn ? actDuty[ch] : 0;
            3:       return (actDuty[ch] * level) / 256;
            default: return 0;
        endcase
    endfunction

    task automatic modelStep();
        int  pos;
        int  p;
        bit  accepted;
        if (reset) begin
            cyc = 0;
            for (int c = 0; c < 3; c++) begin
                shDuty[c]  = 0;
                actDuty[c] = 0;
                expLed[c]  = 1'b0;
            end
            shMode = 0; actMode = 0; shPeriod = 0; actPeriod = 0;
            phaseAge = 0; blinkOn = 1'b1; level = 0; goingUp = 1'b1;
            expReadyReg = 1'b0;
            expFrame = 1'b0;
            modelLive = 1'b1;
            return;
        end
        pos = cyc % FRAME_CLKS;
        for (int c = 0; c < 3; c++) begin
            expLed[c] = ((pos / PS) < effectiveDuty(c));
        end
        expFrame = (pos == FRAME_CLKS - 1);
        accepted = wrIf.wr_valid && expReadyReg;
        if (expFrame) begin
            p = (actPeriod == 0) ? 1 : actPeriod;
            if (shMode != actMode) begin
                phaseAge = 0; blinkOn = 1'b1; level = 0; goingUp = 1'b1;
            end else if (actMode == 2) begin
                phaseAge++;
                if (phaseAge >= p) begin
                    phaseAge = 0;
                    blinkOn  = !blinkOn;
                end
            end else if (actMode == 3) begin
                if (goingUp) begin
                    level = (level + p > 255) ? 255 : level + p;
                    if (level == 255) goingUp = 1'b0;
                end else begin
                    level = (level - p < 0) ? 0 : level - p;
                    if (level == 0) goingUp = 1'b1;
                end
            end
            for (int c = 0; c < 3; c++) actDuty[c] = shDuty[c];
            actMode   = shMode;
            actPeriod = shPeriod;
        end
        if (accepted) begin
            if (wrIf.wr_addr == 2'd3) begin
                shMode   = int'(wrIf.wr_data[7:6]);
                shPeriod = int'(wrIf.wr_data[5:0]);
            end else begin
                shDuty[wrIf.wr_addr] = int'(wrIf.wr_data);
            end
        end
        expReadyReg = 1'b1;
        cyc++;
    endtask

    // Inputs change just after posedge, so at negedge they already hold what the next edge samples.
    always @(negedge clock) begin
        if (modelLive) begin
            checkOutput("led_r", led_r, expLed[0]);
            checkOutput("led_g", led_g, expLed[1]);
            checkOutput("led_b", led_b, expLed[2]);
            checkOutput("frame", frame, expFrame);
            checkOutput("wr_ready", wrIf.wr_ready, expReadyReg && !reset);
        end
        modelStep();
    end

    // The led value visible in a frame-pulse cycle still belongs to the frame just finished.
    always @(negedge clock) begin
        if (frame === 1'b1) begin
            cntR.push_back(accR + int'(led_r));
            cntG.push_back(accG + int'(led_g));
            cntB.push_back(accB + int'(led_b));
            accR = 0; accG = 0; accB = 0;
        end else begin
            accR += int'(led_r === 1'b1);
            accG += int'(led_g === 1'b1);
            accB += int'(led_b === 1'b1);
        end
    end

    task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
        @(posedge clock);
        #1;
        wrIf.wr_valid = 1'b1;
        wrIf.wr_addr  = addr;
        wrIf.wr_data  = data;
        @(posedge clock);
        #1;
        wrIf.wr_valid = 1'b0;
    endtask

    task automatic waitFrames(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                @(negedge clock);
                guard++;
            end while (frame !== 1'b1 && guard <= FRAME_CLKS + 16);
            if (frame !== 1'b1) begin
                total++;
                bad++;
                $display("[TB] FAIL frame_timeout: no frame pulse within %0d clocks, required one", guard);
            end
        end
        #1;
    endtask

    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idx;
        int expB3 [7];
        int expFade [8];
        int fadeOff [8];
        wrIf.wr_valid = 1'b0;
        wrIf.wr_addr  = '0;
        wrIf.wr_data  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_led_r", led_r, 0);
        checkOutput("reset_frame", frame, 0);
        checkOutput("reset_ready", wrIf.wr_ready, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("ready_after_reset", wrIf.wr_ready, 1);

        $display("[TB] static mode, R=0x80");
        applyStimulus(2'd0, 8'h80);
        applyStimulus(2'd3, 8'h40);
        waitFrames(1);
        checkOutput("dark_before_first_frame", cntR[$], 0);
        idx = cntR.size();
        waitFrames(2);
        checkOutput("static_r_f0", cntR[idx], 128);
        checkOutput("static_r_f1", cntR[idx + 1], 128);
        checkOutput("static_g", cntG[idx], 0);
        checkOutput("static_b", cntB[idx], 0);

        $display("[TB] duty extremes on G");
        applyStimulus(2'd1, 8'hFF);
        waitFrames(1);
        idx = cntG.size();
        waitFrames(1);
        checkOutput("g_duty_ff", cntG[idx], 255);
        applyStimulus(2'd1, 8'h00);
        waitFrames(1);
        idx = cntG.size();
        waitFrames(1);
        checkOutput("g_duty_00", cntG[idx], 0);

        $display("[TB] blink P=3 and P=0");
        applyStimulus(2'd2, 8'hFF);
        applyStimulus(2'd3, 8'h83);
        waitFrames(1);
        idx = cntB.size();
        waitFrames(7);
        expB3 = '{255, 255, 255, 0, 0, 0, 255};
        for (int i = 0; i < 7; i++) checkOutput($sformatf("blink3_b_f%0d", i), cntB[idx + i], expB3[i]);
        checkOutput("blink3_r_on", cntR[idx], 128);
        checkOutput("blink3_r_off", cntR[idx + 3], 0);
        applyStimulus(2'd3, 8'h00);
        waitFrames(1);
        applyStimulus(2'd3, 8'h80);
        waitFrames(1);
        idx = cntB.size();
        waitFrames(4);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("blink0_b_f%0d", i), cntB[idx + i], (i % 2 == 0) ? 255 : 0);

        $display("[TB] ctrl write colliding with frame_end");
        applyStimulus(2'd3, 8'h00);
        waitFrames(1);
        repeat (FRAME_CLKS - 1) @(posedge clock);
        #1;
        wrIf.wr_valid = 1'b1;
        wrIf.wr_addr  = 2'd3;
        wrIf.wr_data  = 8'h40;
        @(posedge clock);
        #1;
        wrIf.wr_valid = 1'b0;
        waitFrames(1);
        idx = cntB.size();
        waitFrames(2);
        checkOutput("collision_old_mode", cntB[idx], 0);
        checkOutput("collision_new_mode", cntB[idx + 1], 255);

        $display("[TB] fade P=8");
        applyStimulus(2'd3, 8'h00);
        waitFrames(1);
        applyStimulus(2'd0, 8'hFF);
        applyStimulus(2'd3, 8'hC8);
        waitFrames(1);
        idx = cntR.size();
        waitFrames(66);
        fadeOff = '{0, 1, 31, 32, 33, 63, 64, 65};
        expFade = '{0, 7, 247, 254, 246, 6, 0, 7};
        for (int i = 0; i < 8; i++) checkOutput($sformatf("fade_r_f%0d", fadeOff[i]), cntR[idx + fadeOff[i]], expFade[i]);
        checkOutput("fade_b_peak", cntB[idx + 32], 254);

        $display("[TB] randomized writes");
        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 500)) @(posedge clock);
            applyStimulus(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end

        $display("[TB] reset mid-frame");
        applyStimulus(2'd0, 8'h80);
        applyStimulus(2'd2, 8'hFF);
        applyStimulus(2'd3, 8'h40);
        waitFrames(2);
        repeat (100) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midreset_led_r", led_r, 0);
        checkOutput("midreset_led_b", led_b, 0);
        checkOutput("midreset_ready", wrIf.wr_ready, 0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("midreset_frame", frame, 0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("ready_after_midreset", wrIf.wr_ready, 1);
        waitFrames(1);
        idx = cntR.size();
        waitFrames(2);
        checkOutput("post_reset_r_dark", cntR[idx], 0);
        checkOutput("post_reset_b_dark", cntB[idx + 1], 0);

        repeat (4) @(posedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
